// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a registered borrow.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed overflow_o result port.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             zero_o,
    output logic             overflow_o
`else
    output logic             zero_o
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] next_res;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign next_res = {cell_d, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy_o   = (state == RUN);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand MSBs are shifted out during RUN, so keep copies for the overflow term.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow_o <= 1'b0;
        end else if (state != RUN) begin
            if (start_i) begin
                a_msb <= a_i[WIDTH-1];
                b_msb <= b_i[WIDTH-1];
            end
        end else if (last_bit) begin
            overflow_o <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            done_o   <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            zero_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_sh     <= a_i;
                        b_sh     <= b_i;
                        res_sh   <= '0;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_sh   <= next_res;
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= cell_bout;
                    cnt      <= cnt + CNT_W'(1);
                    // Results are published only here, so they hold through IDLE and the next RUN.
                    if (last_bit) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        diff_o   <= next_res;
                        borrow_o <= cell_bout;
                        zero_o   <= (next_res == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
// Overflow checks are compiled in when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             zero_o;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             overflow_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] held_diff;
    logic             held_borrow;
    logic             held_zero;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .zero_o    (zero_o),
        .overflow_o(overflow_o)
`else
        .zero_o   (zero_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives a start at the current negedge; returns at the negedge where done_o is seen (or on timeout).
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke,
                                 output int lat, output int busy_cycles);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        a_i     = 8'($urandom);
        b_i     = 8'($urandom);
        lat         = 1;
        busy_cycles = 0;
        while (!done_o && lat < 40) begin
            if (busy_o) busy_cycles++;
            if (lat == 4) begin
                checkOutput("hold_diff_in_run", 32'(diff_o), 32'(held_diff));
                checkOutput("hold_borrow_in_run", 32'(borrow_o), 32'(held_borrow));
                checkOutput("hold_zero_in_run", 32'(zero_o), 32'(held_zero));
            end
            if (poke) start_i = (lat == 3);
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
    endtask

    // Checks the result at the done cycle against plain arithmetic on the original operands.
    task automatic checkResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int lat, input int busy_cycles);
        logic [WIDTH-1:0] exp_diff;
        int               sa;
        int               sb;
        exp_diff = WIDTH'(int'(a) - int'(b));
        sa = int'($signed(a));
        sb = int'($signed(b));
        checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
        checkOutput("busy_cycles", 32'(busy_cycles), 32'(WIDTH));
        checkOutput("done_pulse_high", 32'(done_o), 32'd1);
        checkOutput("diff", 32'(diff_o), 32'(exp_diff));
        checkOutput("borrow", 32'(borrow_o), 32'(a < b));
        checkOutput("zero", 32'(zero_o), 32'(a == b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("overflow", 32'(overflow_o), 32'((sa - sb) > 127 || (sa - sb) < -128));
`else
        if (sa < -1000 || sb < -1000) $display("[TB] operand out of range");
`endif
        held_diff   = exp_diff;
        held_borrow = (a < b);
        held_zero   = (a == b);
    endtask

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
        int lat;
        int busy_cycles;
        applyStimulus(a, b, poke, lat, busy_cycles);
        checkResult(a, b, lat, busy_cycles);
        @(negedge clk_i);
        checkOutput("done_pulse_low", 32'(done_o), 32'd0);
        checkOutput("idle_not_busy", 32'(busy_o), 32'd0);
        checkOutput("hold_diff_idle", 32'(diff_o), 32'(held_diff));
    endtask

    initial begin
        int lat;
        int busy_cycles;
        bit saw_done;

        rst_i       = 1'b0;
        start_i     = 1'b0;
        a_i         = '0;
        b_i         = '0;
        held_diff   = '0;
        held_borrow = 1'b0;
        held_zero   = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_diff", 32'(diff_o), 32'd0);
        checkOutput("reset_borrow", 32'(borrow_o), 32'd0);
        checkOutput("reset_zero", 32'(zero_o), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("reset_overflow", 32'(overflow_o), 32'd0);
`endif
        rst_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] directed operands");
        runOp(8'h35, 8'h12, 1'b0);
        runOp(8'h12, 8'h35, 1'b0);
        runOp(8'h55, 8'h55, 1'b0);
        runOp(8'h00, 8'hFF, 1'b0);
        runOp(8'h80, 8'h01, 1'b0);
        runOp(8'h10, 8'h01, 1'b0);
        runOp(8'h7F, 8'h80, 1'b0);

        $display("[TB] start pulsed mid-run");
        runOp(8'hA7, 8'h3C, 1'b1);

        $display("[TB] back-to-back operations");
        applyStimulus(8'h9C, 8'h21, 1'b0, lat, busy_cycles);
        checkResult(8'h9C, 8'h21, lat, busy_cycles);
        applyStimulus(8'h21, 8'h9C, 1'b0, lat, busy_cycles);
        checkResult(8'h21, 8'h9C, lat, busy_cycles);
        @(negedge clk_i);
        checkOutput("b2b_done_low", 32'(done_o), 32'd0);

        $display("[TB] reset during run");
        start_i = 1'b1;
        a_i     = 8'hF0;
        b_i     = 8'h0F;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_done", 32'(done_o), 32'd0);
        checkOutput("abort_diff", 32'(diff_o), 32'd0);
        checkOutput("abort_borrow", 32'(borrow_o), 32'd0);
        checkOutput("abort_zero", 32'(zero_o), 32'd0);
        @(negedge clk_i);
        rst_i       = 1'b1;
        held_diff   = '0;
        held_borrow = 1'b0;
        held_zero   = 1'b0;
        saw_done    = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);
        runOp(8'h64, 8'h19, 1'b0);

        $display("[TB] randomized operands");
        for (int i = 0; i < 20; i++) begin
            runOp(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Companion to the combinational adder datapath. Gives the ALU lab a small-area sequential subtract unit with a start/done handshake.
- Outputs are the difference, borrow-out and zero flag. Results are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous assert, active-low; internally synchronised deassert not required.
- start_i  input  1  request; sampled only when the FSM is in IDLE or DONE.
- a_i  input  WIDTH  minuend; captured on the edge that accepts start_i.
- b_i  input  WIDTH  subtrahend; captured on the same edge as a_i.
- busy_o  output  1  high while in RUN.
- done_o  output  1  single-cycle pulse; results valid from this cycle onward.
- diff_o  output  WIDTH  A − B modulo 2^WIDTH.
- borrow_o  output  1  1 when unsigned A < B.
- zero_o  output  1  1 when diff_o == 0.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; busy_o=0, done_o=0, diff_o=0, borrow_o=0, zero_o=0.
  - Internal shift registers, bit counter and borrow register all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start_i=1, load a_i/b_i into shift regs, clear borrow reg, counter=0, go to RUN. Otherwise stay.
  - RUN:
    - Each edge: cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
    - d shifts into result MSB (right shift); operand regs shift right; borrow reg ← bout; counter increments.
    - On the edge where counter == WIDTH−1, go to DONE.
    - start_i is ignored in RUN; no queueing.
  - DONE:
    - done_o=1 for exactly this one cycle.
    - diff_o/borrow_o/zero_o update on the transition into DONE.
    - Next edge: if start_i=1, accept as from IDLE (back-to-back) and go to RUN; else go to IDLE.
- Latency: start accepted on edge E; done_o high in the cycle after edge E+WIDTH; throughput is one op per WIDTH+1 cycles.
- Output holding:
  - diff_o/borrow_o/zero_o hold their value through IDLE and the following RUN. They change only on entry to DONE.
  - a_i/b_i may change freely after the accepting edge.
- busy_o = (state==RUN); combinational decode of registered state.
- Boundaries:
  - A==B → diff 0, zero 1, borrow 0.
  - A=0, B=all-ones → diff 1, borrow 1.
  - Reset mid-RUN aborts immediately: outputs 0, no done_o.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Extra port overflow_o (output, 1).
  - Signed two's-complement overflow = (A[MSB] ^ B[MSB]) & (A[MSB] ^ diff[MSB]).
  - Uses the captured operand MSBs.
  - Updated on entry to DONE, held like the other results; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit).
  - Default WIDTH constant.
  - Counter width function/constant = $clog2(WIDTH).
- Sub-module full_subtractor: 1-bit, ports a, b, bin → d, bout; pure combinational, instantiated once.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, start 1 cycle → done_o after 8 edges + 1 cycle; diff=0x23, borrow=0, zero=0; busy_o high exactly 8 cycles.
- a=0x12, b=0x35 → diff=0xDD, borrow=1, zero=0.
- a=0x55, b=0x55 → diff=0x00, zero=1, borrow=0. Then a=0x00, b=0xFF → diff=0x01, borrow=1.
- With macro: a=0x80, b=0x01 → diff=0x7F, overflow_o=1. a=0x10, b=0x01 → overflow_o=0. Without macro: compiles with no overflow_o.
- Start pulsed mid-RUN with new operands → ignored; first result unchanged. Start held high in DONE cycle → second op begins immediately; second done_o exactly 9 cycles after the first.
- rst_i low for 1 cycle at RUN bit 4 → busy_o/done_o/outputs 0 immediately. Fresh start afterwards yields a correct result.
